// File: rtl/io_bus_pkg.sv
// io_bus_pkg
// Shared definitions for the dma_io bus initiator:
//   - FSM state encoding of the initiator
//   - requester-id constants (CPU = 0, DBG = 1)
//   - IO word addresses ([15:2]) of the system slaves, for benches and firmware headers
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Requester ids; also used as bit positions in the grant vector.
    localparam logic CPU = 1'b0;
    localparam logic DBG = 1'b1;

    // IO word addresses.
    localparam logic [13:0] SYS_FRC_VALLO = 14'h3E00;
    localparam logic [13:0] SYS_FRC_VALHI = 14'h3E01;
    localparam logic [13:0] SYS_FRC_CMPLO = 14'h3E02;
    localparam logic [13:0] SYS_FRC_CMPHI = 14'h3E03;
    localparam logic [13:0] SYS_FRC_CNTRL = 14'h3E04;
    localparam logic [13:0] SYS_INT_CLEAR = 14'h3E80;

endpackage

// File: rtl/io_rr_arb2.sv
// io_rr_arb2
// Two-way arbiter between the CPU and debug requesters.
// With rr_en = 1 a tie goes to the requester that was not granted last;
// with rr_en = 0 the CPU always wins a tie. A lone valid requester always wins.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   valid_cpu/dbg   request valids
//   rr_en           1 = round-robin, 0 = fixed CPU priority
//   update_en       a grant was consumed this cycle; remember who got it
//   grant[1:0]      one-hot grant, bit CPU / bit DBG (combinational)
module io_rr_arb2
    import io_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_cpu,
    input  logic       valid_dbg,
    input  logic       rr_en,
    input  logic       update_en,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (valid_cpu && valid_dbg) begin
            if (rr_en && (last_grant == CPU))
                grant[DBG] = 1'b1;
            else
                grant[CPU] = 1'b1;
        end else if (valid_cpu) begin
            grant[CPU] = 1'b1;
        end else if (valid_dbg) begin
            grant[DBG] = 1'b1;
        end
    end

    // Reset to DBG so that the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= DBG;
        else if (update_en)
            last_grant <= grant[DBG] ? DBG : CPU;
    end

endmodule

// File: rtl/io_bus_initiator.sv
// io_bus_initiator
// Master end of the dma_io peripheral bus. Takes single-word load/store
// requests from the CPU and debug requesters, arbitrates between them, drives
// one registered write or read strobe, captures the read data one cycle after
// the read strobe and returns a one-cycle response to the owning requester.
// One transaction in flight at a time.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_req_* / dbg_req_*          request channel (valid/ready, we, adr, wdata)
//   cpu_rsp_* / dbg_rsp_*          response pulse and read data (0 for writes)
//   dma_io_we/wadr/wdata           write strobe, word address, data
//   dma_io_radr_en/radr            read strobe, word address
//   dma_io_rdata                   read data, valid one cycle after dma_io_radr_en
// Parameters:
//   RR_EN      1 = round-robin, 0 = CPU always wins a tie
//   IDLE_ZERO  1 = bus address/data are 0 outside their own strobe cycle
module io_bus_initiator
    import io_bus_pkg::*;
#(
    parameter bit RR_EN     = 1'b1,
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_we,
    input  logic [13:0] cpu_req_adr,
    input  logic [31:0] cpu_req_wdata,
    output logic        cpu_rsp_valid,
    output logic [31:0] cpu_rsp_rdata,

    input  logic        dbg_req_valid,
    output logic        dbg_req_ready,
    input  logic        dbg_req_we,
    input  logic [13:0] dbg_req_adr,
    input  logic [31:0] dbg_req_wdata,
    output logic        dbg_rsp_valid,
    output logic [31:0] dbg_rsp_rdata,

    output logic        dma_io_we,
    output logic [13:0] dma_io_wadr,
    output logic [31:0] dma_io_wdata,
    output logic [13:0] dma_io_radr,
    output logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata
);

    state_t           state;
    logic             we_q;
    logic             id_q;
    logic [1:0]       rsp_valid_q;
    logic [1:0][31:0] rsp_rdata_q;

    logic [1:0]  grant;
    logic        idle;
    logic        cpu_hs;
    logic        dbg_hs;
    logic        hs;
    logic        req_we;
    logic [13:0] req_adr;
    logic [31:0] req_wdata;

    io_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_cpu (cpu_req_valid),
        .valid_dbg (dbg_req_valid),
        .rr_en     (RR_EN),
        .update_en (hs),
        .grant     (grant)
    );

    assign idle = (state == ST_IDLE);

    // A requester is held off only while the other one holds the grant, so the
    // arbitration loser sees ready = 0 and both see ready = 1 in an idle,
    // uncontested cycle.
    assign cpu_req_ready = idle & ~grant[DBG];
    assign dbg_req_ready = idle & ~grant[CPU];

    assign cpu_hs = cpu_req_valid & cpu_req_ready;
    assign dbg_hs = dbg_req_valid & dbg_req_ready;
    assign hs     = cpu_hs | dbg_hs;

    assign req_we    = dbg_hs ? dbg_req_we    : cpu_req_we;
    assign req_adr   = dbg_hs ? dbg_req_adr   : cpu_req_adr;
    assign req_wdata = dbg_hs ? dbg_req_wdata : cpu_req_wdata;

    assign cpu_rsp_valid = rsp_valid_q[CPU];
    assign dbg_rsp_valid = rsp_valid_q[DBG];
    assign cpu_rsp_rdata = rsp_rdata_q[CPU];
    assign dbg_rsp_rdata = rsp_rdata_q[DBG];

    // The bus strobes are loaded on the handshake edge so they appear, from
    // registers, in the cycle after the handshake (ISSUE). The response is
    // loaded on the edge leaving ISSUE (write) or CAPT (read) so it is visible
    // during RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            we_q           <= 1'b0;
            id_q           <= CPU;
            dma_io_we      <= 1'b0;
            dma_io_wadr    <= '0;
            dma_io_wdata   <= '0;
            dma_io_radr    <= '0;
            dma_io_radr_en <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
        end else begin
            dma_io_we      <= 1'b0;
            dma_io_radr_en <= 1'b0;
            rsp_valid_q    <= '0;
            if (IDLE_ZERO) begin
                dma_io_wadr  <= '0;
                dma_io_wdata <= '0;
                dma_io_radr  <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        we_q  <= req_we;
                        id_q  <= dbg_hs ? DBG : CPU;
                        state <= ST_ISSUE;
                        if (req_we) begin
                            dma_io_we    <= 1'b1;
                            dma_io_wadr  <= req_adr;
                            dma_io_wdata <= req_wdata;
                        end else begin
                            dma_io_radr_en <= 1'b1;
                            dma_io_radr    <= req_adr;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (we_q) begin
                        rsp_valid_q[id_q] <= 1'b1;
                        rsp_rdata_q[id_q] <= '0;
                        state             <= ST_RESP;
                    end else begin
                        state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    rsp_valid_q[id_q] <= 1'b1;
                    rsp_rdata_q[id_q] <= dma_io_rdata;
                    state             <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_initiator.sv
// tb_io_bus_initiator
// Directed bench for io_bus_initiator. u_dut uses round-robin arbitration,
// u_fix uses fixed CPU priority and shares the request inputs. Inputs change
// and outputs are sampled on the falling clock edge (plus #1 where a
// combinational ready is observed after a stimulus change).
module tb_io_bus_initiator;
    import io_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cpu_req_valid = 1'b0, cpu_req_we = 1'b0;
    logic [13:0] cpu_req_adr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        dbg_req_valid = 1'b0, dbg_req_we = 1'b0;
    logic [13:0] dbg_req_adr = '0;
    logic [31:0] dbg_req_wdata = '0;
    logic [31:0] dma_io_rdata = 32'h0;

    logic        cpu_req_ready, cpu_rsp_valid, dbg_req_ready, dbg_rsp_valid;
    logic [31:0] cpu_rsp_rdata, dbg_rsp_rdata;
    logic        dma_io_we, dma_io_radr_en;
    logic [13:0] dma_io_wadr, dma_io_radr;
    logic [31:0] dma_io_wdata;

    logic        fx_cpu_req_ready, fx_cpu_rsp_valid, fx_dbg_req_ready, fx_dbg_rsp_valid;
    logic [31:0] fx_cpu_rsp_rdata, fx_dbg_rsp_rdata;
    logic        fx_dma_io_we, fx_dma_io_radr_en;
    logic [13:0] fx_dma_io_wadr, fx_dma_io_radr;
    logic [31:0] fx_dma_io_wdata;

    int checks = 0;
    int errors = 0;

    // Slave-chain stub: returns the next table entry one cycle after each read
    // strobe of u_dut, and garbage in every other cycle.
    logic [31:0] stub_vals [16];
    logic [3:0]  stub_cnt = 4'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dma_io_radr_en) begin
            dma_io_rdata <= stub_vals[stub_cnt];
            stub_cnt     <= stub_cnt + 4'd1;
        end else begin
            dma_io_rdata <= 32'hDEADBEEF;
        end
    end

    io_bus_initiator #(.RR_EN(1'b1), .IDLE_ZERO(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
        .cpu_req_adr(cpu_req_adr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
        .dbg_req_adr(dbg_req_adr), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
        .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
        .dma_io_radr(dma_io_radr), .dma_io_radr_en(dma_io_radr_en), .dma_io_rdata(dma_io_rdata)
    );

    io_bus_initiator #(.RR_EN(1'b0), .IDLE_ZERO(1'b1)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(fx_cpu_req_ready), .cpu_req_we(cpu_req_we),
        .cpu_req_adr(cpu_req_adr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(fx_cpu_rsp_valid), .cpu_rsp_rdata(fx_cpu_rsp_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(fx_dbg_req_ready), .dbg_req_we(dbg_req_we),
        .dbg_req_adr(dbg_req_adr), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(fx_dbg_rsp_valid), .dbg_rsp_rdata(fx_dbg_rsp_rdata),
        .dma_io_we(fx_dma_io_we), .dma_io_wadr(fx_dma_io_wadr), .dma_io_wdata(fx_dma_io_wdata),
        .dma_io_radr(fx_dma_io_radr), .dma_io_radr_en(fx_dma_io_radr_en), .dma_io_rdata(dma_io_rdata)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (dma_io_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", dma_io_we); end
        checks++; if (dma_io_radr_en !== 1'b0) begin errors++; $display("FAIL rst_radr_en: got %b want 0", dma_io_radr_en); end
        checks++; if (dma_io_wadr !== 14'h0 || dma_io_radr !== 14'h0 || dma_io_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_bus: wadr %h radr %h wdata %h want all 0", dma_io_wadr, dma_io_radr, dma_io_wdata); end
        checks++; if (cpu_rsp_valid !== 1'b0 || dbg_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_rsp_valid: cpu %b dbg %b want 0 0", cpu_rsp_valid, dbg_rsp_valid); end
        checks++; if (cpu_rsp_rdata !== 32'h0 || dbg_rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_rsp_rdata: cpu %h dbg %h want 0 0", cpu_rsp_rdata, dbg_rsp_rdata); end
        checks++; if (cpu_req_ready !== 1'b1 || dbg_req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready: cpu %b dbg %b want 1 1", cpu_req_ready, dbg_req_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (cpu_req_ready !== 1'b1 || dbg_req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_rel_ready: cpu %b dbg %b want 1 1", cpu_req_ready, dbg_req_ready); end
        $display("test_reset done");
    endtask

    task automatic test_cpu_write();
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_adr = SYS_FRC_CNTRL; cpu_req_wdata = 32'h5;
        #1;
        checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", cpu_req_ready); end
        @(negedge clk); // T+1
        checks++; if (dma_io_we !== 1'b1 || dma_io_radr_en !== 1'b0) begin
            errors++; $display("FAIL wr_strobe: we %b radr_en %b want 1 0", dma_io_we, dma_io_radr_en); end
        checks++; if (dma_io_wadr !== 14'h3E04 || dma_io_wdata !== 32'h5) begin
            errors++; $display("FAIL wr_bus: wadr %h wdata %h want 3e04 5", dma_io_wadr, dma_io_wdata); end
        checks++; if (cpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_early: got %b want 0", cpu_rsp_valid); end
        cpu_req_valid = 1'b0;
        @(negedge clk); // T+2
        checks++; if (dma_io_we !== 1'b0 || dma_io_wadr !== 14'h0 || dma_io_wdata !== 32'h0) begin
            errors++; $display("FAIL wr_drop: we %b wadr %h wdata %h want 0 0 0", dma_io_we, dma_io_wadr, dma_io_wdata); end
        checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_rsp: valid %b rdata %h want 1 0", cpu_rsp_valid, cpu_rsp_rdata); end
        checks++; if (dbg_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_dbg_rsp: got %b want 0", dbg_rsp_valid); end
        @(negedge clk); // T+3
        checks++; if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
            errors++; $display("FAIL wr_end: rsp_valid %b ready %b want 0 1", cpu_rsp_valid, cpu_req_ready); end
        $display("test_cpu_write done");
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        stub_vals[stub_cnt] = 32'h12345678;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_adr = SYS_FRC_VALLO; cpu_req_wdata = 32'h0;
        @(negedge clk); // T+1
        checks++; if (dma_io_radr_en !== 1'b1 || dma_io_we !== 1'b0 || dma_io_radr !== 14'h3E00) begin
            errors++; $display("FAIL rd_strobe: radr_en %b we %b radr %h want 1 0 3e00", dma_io_radr_en, dma_io_we, dma_io_radr); end
        cpu_req_valid = 1'b0;
        @(negedge clk); // T+2
        checks++; if (dma_io_radr_en !== 1'b0 || dma_io_radr !== 14'h0 || cpu_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_capt: radr_en %b radr %h rsp_valid %b want 0 0 0", dma_io_radr_en, dma_io_radr, cpu_rsp_valid); end
        @(negedge clk); // T+3
        checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'h12345678) begin
            errors++; $display("FAIL rd_rsp: valid %b rdata %h want 1 12345678", cpu_rsp_valid, cpu_rsp_rdata); end
        checks++; if (dbg_rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_dbg_rsp: got %b want 0", dbg_rsp_valid); end
        @(negedge clk); // T+4
        checks++; if (cpu_rsp_valid !== 1'b0 || cpu_rsp_rdata !== 32'h12345678 || cpu_req_ready !== 1'b1) begin
            errors++; $display("FAIL rd_hold: valid %b rdata %h ready %b want 0 12345678 1", cpu_rsp_valid, cpu_rsp_rdata, cpu_req_ready); end
        $display("test_cpu_read done");
    endtask

    task automatic test_round_robin();
        logic [3:0]  idx;
        logic        exp_dbg;
        logic [13:0] exp_adr;
        logic [31:0] exp_data;
        logic        own_v, oth_v;
        logic [31:0] own_d;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idx = stub_cnt + 4'(k);
            stub_vals[idx] = 32'hA0 + 32'(k);
        end
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_adr = SYS_FRC_VALLO;
        dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_adr = SYS_FRC_VALHI;
        for (int k = 0; k < 4; k++) begin
            exp_dbg  = (k == 1 || k == 3);
            exp_adr  = exp_dbg ? 14'h3E01 : 14'h3E00;
            exp_data = 32'hA0 + 32'(k);
            #1;
            checks++; if (cpu_req_ready !== !exp_dbg || dbg_req_ready !== exp_dbg) begin
                errors++; $display("FAIL rr_grant%0d: ready cpu %b dbg %b want %b %b", k, cpu_req_ready, dbg_req_ready, !exp_dbg, exp_dbg); end
            @(negedge clk); // T+1
            checks++; if (dma_io_radr_en !== 1'b1 || dma_io_radr !== exp_adr) begin
                errors++; $display("FAIL rr_strobe%0d: radr_en %b radr %h want 1 %h", k, dma_io_radr_en, dma_io_radr, exp_adr); end
            if (k >= 2) begin
                if (exp_dbg) dbg_req_valid = 1'b0; else cpu_req_valid = 1'b0;
            end
            @(negedge clk);
            @(negedge clk); // T+3
            own_v = exp_dbg ? dbg_rsp_valid : cpu_rsp_valid;
            oth_v = exp_dbg ? cpu_rsp_valid : dbg_rsp_valid;
            own_d = exp_dbg ? dbg_rsp_rdata : cpu_rsp_rdata;
            checks++; if (own_v !== 1'b1 || oth_v !== 1'b0 || own_d !== exp_data) begin
                errors++; $display("FAIL rr_rsp%0d: own_valid %b other_valid %b rdata %h want 1 0 %h", k, own_v, oth_v, own_d, exp_data); end
            @(negedge clk); // T+4
        end
        $display("test_round_robin done");
    endtask

    task automatic test_fixed_priority();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_adr = SYS_FRC_VALHI; cpu_req_wdata = 32'h11;
        dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_adr = SYS_FRC_CMPLO; dbg_req_wdata = 32'h22;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (fx_cpu_req_ready !== 1'b1 || fx_dbg_req_ready !== 1'b0) begin
                errors++; $display("FAIL fx_grant%0d: ready cpu %b dbg %b want 1 0", k, fx_cpu_req_ready, fx_dbg_req_ready); end
            @(negedge clk);
            checks++; if (fx_dma_io_we !== 1'b1 || fx_dma_io_wadr !== 14'h3E01 || fx_dbg_req_ready !== 1'b0) begin
                errors++; $display("FAIL fx_wr%0d: we %b wadr %h dbg_ready %b want 1 3e01 0", k, fx_dma_io_we, fx_dma_io_wadr, fx_dbg_req_ready); end
            repeat (2) @(negedge clk);
        end
        cpu_req_valid = 1'b0;
        #1;
        checks++; if (fx_dbg_req_ready !== 1'b1) begin errors++; $display("FAIL fx_dbg_ready: got %b want 1", fx_dbg_req_ready); end
        @(negedge clk);
        checks++; if (fx_dma_io_we !== 1'b1 || fx_dma_io_wadr !== 14'h3E02 || fx_dma_io_wdata !== 32'h22) begin
            errors++; $display("FAIL fx_dbg_wr: we %b wadr %h wdata %h want 1 3e02 22", fx_dma_io_we, fx_dma_io_wadr, fx_dma_io_wdata); end
        dbg_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (fx_dbg_rsp_valid !== 1'b1 || fx_cpu_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL fx_dbg_rsp: dbg %b cpu %b want 1 0", fx_dbg_rsp_valid, fx_cpu_rsp_valid); end
        @(negedge clk);
        $display("test_fixed_priority done");
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_we, exp_re, exp_rdy, exp_rsp;
        exp_we  = 11'h012; // cycles 1, 4
        exp_re  = 11'h080; // cycle 7
        exp_rdy = 11'h449; // cycles 0, 3, 6, 10
        exp_rsp = 11'h224; // cycles 2, 5, 9
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        stub_vals[stub_cnt] = 32'hCAFE0001;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_adr = SYS_FRC_VALLO; cpu_req_wdata = 32'h111;
        for (int c = 0; c < 11; c++) begin
            #1;
            checks++; if (cpu_req_ready !== exp_rdy[c] || dma_io_we !== exp_we[c] || dma_io_radr_en !== exp_re[c] || cpu_rsp_valid !== exp_rsp[c]) begin
                errors++; $display("FAIL b2b_c%0d: ready %b we %b radr_en %b rsp %b want %b %b %b %b", c,
                    cpu_req_ready, dma_io_we, dma_io_radr_en, cpu_rsp_valid, exp_rdy[c], exp_we[c], exp_re[c], exp_rsp[c]); end
            checks++; if ((!dma_io_we && (dma_io_wadr !== 14'h0 || dma_io_wdata !== 32'h0)) || (!dma_io_radr_en && dma_io_radr !== 14'h0)) begin
                errors++; $display("FAIL b2b_idle_zero_c%0d: wadr %h wdata %h radr %h want 0 outside strobe", c, dma_io_wadr, dma_io_wdata, dma_io_radr); end
            if (c == 1) begin
                checks++; if (dma_io_wadr !== 14'h3E00 || dma_io_wdata !== 32'h111) begin
                    errors++; $display("FAIL b2b_w1: wadr %h wdata %h want 3e00 111", dma_io_wadr, dma_io_wdata); end
                cpu_req_adr = SYS_FRC_VALHI; cpu_req_wdata = 32'h222;
            end
            if (c == 4) begin
                checks++; if (dma_io_wadr !== 14'h3E01 || dma_io_wdata !== 32'h222) begin
                    errors++; $display("FAIL b2b_w2: wadr %h wdata %h want 3e01 222", dma_io_wadr, dma_io_wdata); end
                cpu_req_we = 1'b0; cpu_req_adr = SYS_FRC_CNTRL; cpu_req_wdata = 32'h0;
            end
            if (c == 7) begin
                checks++; if (dma_io_radr !== 14'h3E04) begin errors++; $display("FAIL b2b_radr: got %h want 3e04", dma_io_radr); end
                cpu_req_valid = 1'b0;
            end
            if (c == 9) begin
                checks++; if (cpu_rsp_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL b2b_rdata: got %h want cafe0001", cpu_rsp_rdata); end
            end
            @(negedge clk);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        stub_vals[stub_cnt] = 32'h0BAD0BAD;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_adr = SYS_FRC_VALLO;
        @(negedge clk); // ISSUE
        checks++; if (dma_io_radr_en !== 1'b1) begin errors++; $display("FAIL rm_strobe: got %b want 1", dma_io_radr_en); end
        cpu_req_valid = 1'b0;
        @(negedge clk); // CAPT
        rst_n = 1'b0;
        #1;
        checks++; if (dma_io_we !== 1'b0 || dma_io_radr_en !== 1'b0 || dma_io_radr !== 14'h0 || dma_io_wadr !== 14'h0 || dma_io_wdata !== 32'h0) begin
            errors++; $display("FAIL rm_bus: we %b radr_en %b radr %h wadr %h wdata %h want all 0", dma_io_we, dma_io_radr_en, dma_io_radr, dma_io_wadr, dma_io_wdata); end
        checks++; if (cpu_rsp_rdata !== 32'h0 || dbg_rsp_rdata !== 32'h0 || cpu_req_ready !== 1'b1 || dbg_req_ready !== 1'b1) begin
            errors++; $display("FAIL rm_state: rdata cpu %h dbg %h ready %b %b want 0 0 1 1", cpu_rsp_rdata, dbg_rsp_rdata, cpu_req_ready, dbg_req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (cpu_rsp_valid !== 1'b0 || dbg_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rm_no_rsp%0d: cpu %b dbg %b want 0 0", c, cpu_rsp_valid, dbg_rsp_valid); end
        end
        stub_vals[stub_cnt] = 32'h600DF00D;
        cpu_req_valid = 1'b1; cpu_req_adr = SYS_INT_CLEAR;
        #1;
        checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", cpu_req_ready); end
        @(negedge clk);
        checks++; if (dma_io_radr_en !== 1'b1 || dma_io_radr !== 14'h3E80) begin
            errors++; $display("FAIL rm_new_strobe: radr_en %b radr %h want 1 3e80", dma_io_radr_en, dma_io_radr); end
        cpu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'h600DF00D) begin
            errors++; $display("FAIL rm_new_rsp: valid %b rdata %h want 1 600df00d", cpu_rsp_valid, cpu_rsp_rdata); end
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) stub_vals[i] = 32'h0;
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_round_robin();
        test_fixed_priority();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
